// File: rtl/kmeans_pkg.sv
// Shared types and helpers for the k-means cluster accumulator.
//   coord_t / acc_t / cnt_t : default-width coordinate, sum and count types
//   acc_state_e             : accumulator FSM states
//   sat_add                 : zero-extending saturating adder with overflow flag
package kmeans_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 64;
  localparam int unsigned CNT_W_DEF  = 32;

  // Widest operand sat_add handles; all ACC_W/CNT_W must not exceed this.
  localparam int unsigned SAT_W = 128;

  typedef logic [DATA_W_DEF-1:0] coord_t;
  typedef logic [ACC_W_DEF-1:0]  acc_t;
  typedef logic [CNT_W_DEF-1:0]  cnt_t;

  typedef enum logic {
    ACCUM,
    DRAIN
  } acc_state_e;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] value;
  } sat_res_t;

  // Adds two zero-extended operands and clamps to 2**width-1.
  // width is a constant at every call site, so this folds to a plain
  // adder plus a carry-out compare.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] acc,
                                       input logic [SAT_W-1:0] addend,
                                       input int unsigned      width);
    logic [SAT_W:0] full;
    logic [SAT_W:0] one;
    logic [SAT_W:0] maxv;
    sat_res_t       res;
    one  = {{SAT_W{1'b0}}, 1'b1};
    full = {1'b0, acc} + {1'b0, addend};
    maxv = (one << width) - one;
    if (full > maxv) begin
      res.ovf   = 1'b1;
      res.value = maxv[SAT_W-1:0];
    end else begin
      res.ovf   = 1'b0;
      res.value = full[SAT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cluster_accumulator_bank.sv
// One cluster's storage: D saturating per-dimension sums and a point count.
//   clk, rst_n  : clock, async active-low reset
//   add_en      : accumulate point into this cluster at the next posedge
//   point       : D coordinates, dim j at [j*DATA_W +: DATA_W]
//   clr         : zero sums and count (dominates add_en)
//   sums        : D sums, dim j at [j*ACC_W +: ACC_W]
//   count       : number of points accumulated
//   ovf_strobe  : combinational; this add saturates a sum or the count
module cluster_bank
  import kmeans_pkg::*;
#(
  parameter int unsigned D      = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add_en,
  input  logic [D*DATA_W-1:0] point,
  input  logic                clr,
  output logic [D*ACC_W-1:0]  sums,
  output logic [CNT_W-1:0]    count,
  output logic                ovf_strobe
);

  logic [D*ACC_W-1:0] sums_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic [D:0]         sat;
  sat_res_t           res;

  always_comb begin
    sums_nxt  = '0;
    count_nxt = '0;
    sat       = '0;
    res       = '0;
    for (int unsigned j = 0; j < D; j++) begin
      res = sat_add(SAT_W'(sums[j*ACC_W +: ACC_W]),
                    SAT_W'(point[j*DATA_W +: DATA_W]), ACC_W);
      sums_nxt[j*ACC_W +: ACC_W] = res.value[ACC_W-1:0];
      sat[j]                     = res.ovf;
    end
    res       = sat_add(SAT_W'(count), SAT_W'(1'b1), CNT_W);
    count_nxt = res.value[CNT_W-1:0];
    sat[D]    = res.ovf;
  end

  assign ovf_strobe = add_en & (|sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sums  <= '0;
      count <= '0;
    end else if (clr) begin
      sums  <= '0;
      count <= '0;
    end else if (add_en) begin
      sums  <= sums_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/cluster_accumulator.sv
// Per-cluster sum/count accumulator for the k-means update step.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : classified point handshake (ready only in ACCUM)
//   in_point, in_id       : D packed coordinates and target cluster id
//   clear                 : zero all sums/counts and ovf, abort any drain
//   drain_req             : start read-and-clear readout of all K clusters
//   out_valid/out_ready   : drained record handshake
//   out_id/out_sum/out_count : record contents (0 outside DRAIN)
//   ovf                   : sticky saturation flag
//   busy                  : high while draining
//   drain_done            : one-cycle pulse after the last record is taken
module cluster_accumulator
  import kmeans_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned D      = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [D*DATA_W-1:0] in_point,
  input  logic [N-1:0]        in_id,
  input  logic                clear,
  input  logic                drain_req,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_id,
  output logic [D*ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]    out_count,
  output logic                ovf,
  output logic                busy,
  output logic                drain_done
);

  localparam int unsigned K = 1 << N;

  acc_state_e         state;
  logic [N-1:0]       idx;
  logic [D*ACC_W-1:0] bank_sums [K];
  logic [CNT_W-1:0]   bank_cnt  [K];
  logic [K-1:0]       bank_ovf;
  logic               accept_in;
  logic               accept_out;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state == DRAIN);
  assign out_valid = busy;

  // clear discards any coincident point and any coincident record accept.
  assign accept_in  = in_valid & in_ready & ~clear;
  assign accept_out = out_valid & out_ready & ~clear;

  for (genvar i = 0; i < K; i++) begin : g_bank
    cluster_bank #(
      .D      (D),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .CNT_W  (CNT_W)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .add_en     (accept_in && (in_id == N'(i))),
      .point      (in_point),
      .clr        (clear || (accept_out && (idx == N'(i)))),
      .sums       (bank_sums[i]),
      .count      (bank_cnt[i]),
      .ovf_strobe (bank_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      idx        <= '0;
      ovf        <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      if (clear) begin
        state <= ACCUM;
        idx   <= '0;
        ovf   <= 1'b0;
      end else begin
        if (|bank_ovf) begin
          ovf <= 1'b1;
        end
        case (state)
          ACCUM: begin
            if (drain_req) begin
              state <= DRAIN;
              idx   <= '0;
            end
          end
          DRAIN: begin
            if (out_ready) begin
              if (idx == N'(K - 1)) begin
                state      <= ACCUM;
                idx        <= '0;
                drain_done <= 1'b1;
              end else begin
                idx <= idx + N'(1);
              end
            end
          end
          default: begin
            state <= ACCUM;
          end
        endcase
      end
    end
  end

  always_comb begin
    out_id    = '0;
    out_sum   = '0;
    out_count = '0;
    if (busy) begin
      out_id    = idx;
      out_sum   = bank_sums[idx];
      out_count = bank_cnt[idx];
    end
  end

endmodule
